// File: rtl/float_to_int_seq.sv
// Sequential IEEE-754 single to int32 converter: truncates toward zero,
// shifting the mantissa one bit per clock and saturating on overflow or Inf/NaN.
module float_to_int_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [31:0] y,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic        sign;
  logic        shift_left;
  logic [31:0] mag;
  logic [4:0]  cnt;
  logic        special;
  logic [31:0] special_y;
  logic        special_ovf;

  logic [7:0]  exp_a;
  logic [7:0]  exp_diff;
  logic [31:0] d_mag;
  logic [4:0]  d_cnt;
  logic        d_left;
  logic        d_special;
  logic [31:0] d_special_y;
  logic        d_special_ovf;

  assign exp_a = a[30:23];

  // Classify the operand; biased exponent 150 means the mantissa is already an integer.
  always_comb begin
    d_mag         = {8'd0, 1'b1, a[22:0]};
    d_cnt         = 5'd0;
    d_left        = 1'b0;
    d_special     = 1'b0;
    d_special_y   = 32'd0;
    d_special_ovf = 1'b0;
    exp_diff      = 8'd0;
    if (exp_a == 8'd255) begin
      d_special     = 1'b1;
      d_special_ovf = 1'b1;
      d_special_y   = (a[31] && (a[22:0] == 23'd0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (exp_a < 8'd127) begin
      d_special = 1'b1;
    end else if (exp_a >= 8'd158) begin
      d_special = 1'b1;
      if (a == 32'hCF00_0000) begin
        d_special_y = 32'h8000_0000;
      end else begin
        d_special_ovf = 1'b1;
        d_special_y   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (exp_a <= 8'd149) begin
      exp_diff = 8'd150 - exp_a;
      d_cnt    = exp_diff[4:0];
    end else begin
      exp_diff = exp_a - 8'd150;
      d_cnt    = exp_diff[4:0];
      d_left   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == 5'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign        <= 1'b0;
      shift_left  <= 1'b0;
      mag         <= 32'd0;
      cnt         <= 5'd0;
      special     <= 1'b0;
      special_y   <= 32'd0;
      special_ovf <= 1'b0;
      y           <= 32'd0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign        <= a[31];
            shift_left  <= d_left;
            mag         <= d_mag;
            cnt         <= d_cnt;
            special     <= d_special;
            special_y   <= d_special_y;
            special_ovf <= d_special_ovf;
          end
        end
        SHIFT: begin
          if (cnt != 5'd0) begin
            mag <= shift_left ? (mag << 1) : (mag >> 1);
            cnt <= cnt - 5'd1;
          end else if (special) begin
            y        <= special_y;
            overflow <= special_ovf;
          end else begin
            y        <= sign ? (~mag + 32'd1) : mag;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
